fp_add_sched: RTL

- Round-robin scheduler that shares one fixed-latency FP adder core among NREQ requesters.
- Operands use the 37-bit adder format: bit 36 sign, bits 35:28 exponent, bits 27:0 mantissa.
- Issues at most one operation per cycle to the core.
- Tracks in-flight tags through the core latency and returns each sum to its requester through a per-requester hold register with valid/ready backpressure.

---
 rtl/fp_add_sched_pkg.sv | 29 ++
 rtl/fp_add_sched_if.sv | 35 +++
 rtl/fp_add_sched_rr_arbiter.sv | 37 +++
 rtl/fp_add_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pkg
//  Description : Shared definitions for the FP adder scheduler: operand
//                field layout, requester state encoding and a subnormal
//                exponent test.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_add_pkg;

  localparam int FP_W     = 37;
  localparam int EXP_MSB  = 35;
  localparam int EXP_LSB  = 28;
  localparam int SIGN_BIT = 36;
  localparam int MAN_W    = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } req_state_t;

  // An all-zero exponent marks a zero/subnormal operand.
  function automatic logic is_subnormal(input logic [EXP_MSB-EXP_LSB:0] exp);
    return (exp == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_sched_if
//  Description : Requester-side bus of the FP adder scheduler. Operands and
//                results are packed, requester i at [i*FP_W +: FP_W].
//  Ports       : req_valid/req_ready/req_a/req_b  operation request
//                rsp_valid/rsp_ready/rsp_data     result return
//  Modports    : master = requester side, slave = scheduler side
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_add_sched_if #(
  parameter int NREQ = 4
) ();
  import fp_add_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [NREQ*FP_W-1:0] rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/fp_add_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first set
//                request at or after rr_ptr, searching upward with wrap.
//  Ports       : req     in   NREQ  request vector
//                rr_ptr  in   TAGW  highest-priority index
//                grant   out  NREQ  one-hot grant (zero when no request)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  wire logic [NREQ-1:0] req,
  input  wire logic [TAGW-1:0] rr_ptr,
  output logic      [NREQ-1:0] grant
);

  logic            w_found;
  logic [TAGW-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = TAGW'((int'(rr_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_sched
//  Description : Round-robin scheduler sharing one fixed-latency FP adder core
//                among NREQ requesters. One issue per cycle; in-flight tags
//                follow the core latency and each sum lands in a per-requester
//                hold register drained with valid/ready.
//  Ports       : clk, rst                      clock, sync active-high reset
//                bus (fp_add_sched_if.slave)   requester request/response
//                core_valid/core_a/core_b      issue to adder core
//                core_res                      core sum, LAT after core_valid
//  Options     : FP_SUBNORM_BYPASS_EN - pairs of zero-exponent operands skip
//                the core and return a flush-to-zero result one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_add_sched
  import fp_add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  wire logic              clk,
  input  wire logic              rst,
  fp_add_sched_if.slave          bus,
  output logic                   core_valid,
  output logic      [FP_W-1:0]   core_a,
  output logic      [FP_W-1:0]   core_b,
  input  wire logic [FP_W-1:0]   core_res
);

  localparam int TAGW = $clog2(NREQ);

  req_state_t       r_state     [NREQ];
  req_state_t       w_state_nxt [NREQ];
  logic [TAGW-1:0]  r_rr_ptr;
  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_grant;
  logic             w_any;
  logic [TAGW-1:0]  w_gidx;
  logic [FP_W-1:0]  w_a [NREQ];
  logic [FP_W-1:0]  w_b [NREQ];
  logic [FP_W-1:0]  w_ga;
  logic [FP_W-1:0]  w_gb;
  logic             w_byp;
  logic             w_issue;

  logic             r_core_valid;
  logic [FP_W-1:0]  r_core_a;
  logic [FP_W-1:0]  r_core_b;
  logic [TAGW-1:0]  r_issue_tag;

  // Tag pipeline is fed from the issue register, so its tail lines up with
  // core_res arriving LAT cycles after core_valid.
  logic [LAT-1:0]   r_pv;
  logic [TAGW-1:0]  r_pt [LAT];
  logic             w_cap_valid;
  logic [TAGW-1:0]  w_cap_tag;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_a[i]    = bus.req_a[i*FP_W +: FP_W];
      assign w_b[i]    = bus.req_b[i*FP_W +: FP_W];
      assign w_elig[i] = ~rst & bus.req_valid[i] & (r_state[i] == IDLE);
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
    .req    (w_elig),
    .rr_ptr (r_rr_ptr),
    .grant  (w_grant)
  );

  assign w_any         = |w_grant;
  assign bus.req_ready = w_grant;

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gidx = TAGW'(i);
    end
  end

  assign w_ga = w_a[w_gidx];
  assign w_gb = w_b[w_gidx];

`ifdef FP_SUBNORM_BYPASS_EN
  logic [FP_W-1:0] w_flush;
  assign w_byp   = w_any & is_subnormal(w_ga[EXP_MSB:EXP_LSB])
                         & is_subnormal(w_gb[EXP_MSB:EXP_LSB]);
  assign w_flush = {w_ga[SIGN_BIT] & w_gb[SIGN_BIT],
                    {(EXP_MSB-EXP_LSB+1){1'b0}}, {MAN_W{1'b0}}};
`else
  assign w_byp = 1'b0;
`endif

  assign w_issue = w_any & ~w_byp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (w_gidx == TAGW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Issue register; operands hold their last value between issues
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_valid <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_issue_tag  <= '0;
    end else begin
      r_core_valid <= w_issue;
      if (w_issue) begin
        r_core_a    <= w_ga;
        r_core_b    <= w_gb;
        r_issue_tag <= w_gidx;
      end
    end
  end

  assign core_valid = r_core_valid;
  assign core_a     = r_core_a;
  assign core_b     = r_core_b;

  // --------------------------------------------------------------------------
  // Tag pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int k = 0; k < LAT; k++) r_pt[k] <= '0;
    end else begin
      r_pv[0] <= r_core_valid;
      r_pt[0] <= r_issue_tag;
      for (int k = 1; k < LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pt[k] <= r_pt[k-1];
      end
    end
  end

  assign w_cap_valid = r_pv[LAT-1];
  assign w_cap_tag   = r_pt[LAT-1];

  // --------------------------------------------------------------------------
  // Per-requester state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_state[i] <= IDLE;
    end else begin
      for (int i = 0; i < NREQ; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        IDLE:    if (w_grant[i]) w_state_nxt[i] = w_byp ? HOLD : BUSY;
        BUSY:    if (w_cap_valid && (w_cap_tag == TAGW'(i))) w_state_nxt[i] = HOLD;
        // Leaving HOLD returns to IDLE first, so no same-cycle re-grant.
        HOLD:    if (bus.rsp_ready[i]) w_state_nxt[i] = IDLE;
        default: w_state_nxt[i] = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Hold registers; only written outside HOLD, so data is stable while valid
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_hold
      logic [FP_W-1:0] r_hold;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_hold <= '0;
        end else if (w_cap_valid && (w_cap_tag == TAGW'(i))) begin
          r_hold <= core_res;
`ifdef FP_SUBNORM_BYPASS_EN
        end else if (w_grant[i] && w_byp) begin
          r_hold <= w_flush;
`endif
        end
      end

      assign bus.rsp_data[i*FP_W +: FP_W] = r_hold;
      assign bus.rsp_valid[i]             = (r_state[i] == HOLD);
    end
  endgenerate

endmodule
`default_nettype wire
